voice_env_osc: RTL

VOICE_ENV_OSC -- requirements
Module: voice_env_osc

---
 rtl/voice_env_osc_if.sv | 20 ++
 rtl/voice_env_osc.sv | 135 +++++++++++++
 2 files changed

// File: rtl/voice_env_osc_if.sv
// Control and sample bus for one synthesizer voice: pitch divider, note strobes,
// and the voice's sample and envelope observation outputs.
interface voice_env_osc_if;
    logic [11:0] divider;
    logic        note_on;
    logic        note_off;
    logic [7:0]  sample;
    logic [7:0]  env_level;
    logic [2:0]  env_state;

    modport master (
        output divider, note_on, note_off,
        input  sample, env_level, env_state
    );

    modport slave (
        input  divider, note_on, note_off,
        output sample, env_level, env_state
    );
endinterface

// File: rtl/voice_env_osc.sv
// One synthesizer voice: 32-step triangle oscillator scaled by an ADSR-style
// envelope (attack, decay to sustain, sustain, release), offset-binary output.
//
// state   | meaning
// IDLE    | silent, level 0, waiting for note_on
// ATTACK  | level rises by ATTACK_STEP per tick until 255
// DECAY   | level falls by 1 per tick down to SUSTAIN_LEVEL
// SUSTAIN | level held until note_off
// RELEASE | level falls by 1 per tick down to 0, then IDLE
module voice_env_osc #(
    parameter int ENV_TICK      = 1024,
    parameter int ATTACK_STEP   = 8,
    parameter int SUSTAIN_LEVEL = 160
) (
    input logic           clk,
    input logic           rst,
    voice_env_osc_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] TICK_LAST = 16'(ENV_TICK - 1);
    localparam logic [8:0]  STEP      = 9'(ATTACK_STEP);
    localparam logic [7:0]  SUS_LVL   = 8'(SUSTAIN_LEVEL);

    logic [15:0]        presc_q;
    logic               tick;
    logic [11:0]        cnt_q;
    logic [4:0]         phase_q;
    env_state_t         state_q, state_nx;
    logic [7:0]         level_q, level_nx;
    logic [8:0]         attack_sum;
    logic [7:0]         level_dec;
    logic [3:0]         tri_idx;
    logic [7:0]         raw;
    logic signed [7:0]  wave;
    logic signed [15:0] prod;
    logic signed [15:0] scaled;
    logic [7:0]         sample_q;

    assign tick = (presc_q == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + 16'd1;
    end

    // A retrigger restarts the waveform at phase 0 so every note starts alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (bus.note_on || bus.divider == 12'd0) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (cnt_q >= bus.divider - 12'd1) begin
            cnt_q   <= '0;
            phase_q <= phase_q + 5'd1;
        end else begin
            cnt_q   <= cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
        end else begin
            state_q <= state_nx;
            level_q <= level_nx;
        end
    end

    assign attack_sum = {1'b0, level_q} + STEP;
    assign level_dec  = level_q - 8'd1;

    // Strobes take priority over the tick; the level is left untouched on a strobe cycle.
    always_comb begin
        state_nx = state_q;
        level_nx = level_q;
        if (bus.note_on) begin
            state_nx = ATTACK;
        end else if (bus.note_off &&
                     (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_nx = RELEASE;
        end else if (tick) begin
            case (state_q)
                IDLE:    level_nx = 8'd0;
                ATTACK: begin
                    if (attack_sum >= 9'd255) begin
                        level_nx = 8'd255;
                        state_nx = DECAY;
                    end else begin
                        level_nx = attack_sum[7:0];
                    end
                end
                DECAY: begin
                    level_nx = level_dec;
                    if (level_dec <= SUS_LVL) state_nx = SUSTAIN;
                end
                SUSTAIN: level_nx = level_q;
                RELEASE: begin
                    if (level_q != 8'd0) level_nx = level_dec;
                    if (level_q <= 8'd1) state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    level_nx = 8'd0;
                end
            endcase
        end
    end

    assign tri_idx = phase_q[4] ? ~phase_q[3:0] : phase_q[3:0];
    assign raw     = {tri_idx, 4'b0000};
    assign wave    = $signed(raw - 8'd120);
    assign prod    = $signed({{8{wave[7]}}, wave}) * $signed({8'd0, level_q});
    assign scaled  = (prod >>> 8) + 16'sd128;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        sample_q <= 8'h80;
        else if (bus.divider == 12'd0)  sample_q <= 8'h80;
        else                            sample_q <= 8'(scaled);
    end

    assign bus.sample    = sample_q;
    assign bus.env_level = level_q;
    assign bus.env_state = state_q;
endmodule
